// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit.
// funct3 encodings, FSM state type and the ALU-compatible status bit indices.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Status flag positions, same order as the ALU: {N,Z,C,V}
  localparam int ST_N = 3;
  localparam int ST_Z = 2;
  localparam int ST_C = 1;
  localparam int ST_V = 0;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, one iteration per cycle.
// Optional build macro MULDIV_EARLY_OUT_EN adds zero-operand and |a|<|b|
// shortcuts straight to DONE; results are identical without it.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DataWidth = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2:0]           funct3,
  input  logic [DataWidth-1:0] a,
  input  logic [DataWidth-1:0] b,
  output logic                 busy,
  output logic                 done,
  output logic [DataWidth-1:0] result,
  output logic [3:0]           status
);

  localparam int CW = $clog2(DataWidth);
  localparam logic [CW-1:0] CntLast = CW'(DataWidth - 1);
  localparam logic [DataWidth-1:0] MinNeg = {1'b1, {(DataWidth-1){1'b0}}};

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  muldiv_op_e           op_q, op_d;
  logic [DataWidth-1:0] hi_q, hi_d, lo_q, lo_d, m_q, m_d;
  logic                 negr_q, negr_d;   // negate product / quotient
  logic                 nega_q, nega_d;   // negate remainder
  logic [DataWidth-1:0] result_q, result_d;
  logic [3:0]           status_q, status_d;

  function automatic logic [3:0] flags(input logic [DataWidth-1:0] r);
    logic [3:0] f;
    f       = '0;
    f[ST_N] = r[DataWidth-1];
    f[ST_Z] = (r == '0);
    return f;
  endfunction

  muldiv_op_e           op_in;
  logic                 sgn_a, sgn_b, a_neg, b_neg;
  logic [DataWidth-1:0] a_mag, b_mag;

  assign op_in = muldiv_op_e'(funct3);

  // Operand signedness per op and sign-corrected magnitudes
  always_comb begin
    sgn_a = 1'b0;
    sgn_b = 1'b0;
    unique case (op_in)
      OP_MUL, OP_MULH, OP_DIV, OP_REM: begin sgn_a = 1'b1; sgn_b = 1'b1; end
      OP_MULHSU:                       sgn_a = 1'b1;
      default:                         ;
    endcase
    a_neg = sgn_a & a[DataWidth-1];
    b_neg = sgn_b & b[DataWidth-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
  end

  logic                 fast;
  logic [DataWidth-1:0] fast_res;

  // Cases resolved without iterating (div-by-zero, signed overflow, early-out)
  always_comb begin
    fast     = 1'b0;
    fast_res = '0;
    if (funct3[2]) begin
      if (b == '0) begin
        fast     = 1'b1;
        fast_res = funct3[1] ? a : '1;
      end else if ((op_in == OP_DIV || op_in == OP_REM) && a == MinNeg && b == '1) begin
        fast     = 1'b1;
        fast_res = (op_in == OP_DIV) ? MinNeg : '0;
      end
`ifdef MULDIV_EARLY_OUT_EN
      else if (a_mag < b_mag) begin
        fast     = 1'b1;
        fast_res = funct3[1] ? a : '0;
      end
`endif
    end
`ifdef MULDIV_EARLY_OUT_EN
    else if (a == '0 || b == '0) begin
      fast     = 1'b1;
      fast_res = '0;
    end
`endif
  end

  logic [DataWidth:0]     mul_sum, rem_sh, rem_try;
  logic [DataWidth-1:0]   it_hi, it_lo;
  logic [2*DataWidth-1:0] prod, prod_fix;
  logic [DataWidth-1:0]   quo, remv, fin;

  // One iteration step plus the sign fix-up applied on the last step
  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    rem_sh  = {hi_q, lo_q[DataWidth-1]};
    rem_try = rem_sh - {1'b0, m_q};
    if (op_q[2]) begin
      if (!rem_try[DataWidth]) begin
        it_hi = rem_try[DataWidth-1:0];
        it_lo = {lo_q[DataWidth-2:0], 1'b1};
      end else begin
        it_hi = rem_sh[DataWidth-1:0];
        it_lo = {lo_q[DataWidth-2:0], 1'b0};
      end
    end else begin
      it_hi = mul_sum[DataWidth:1];
      it_lo = {mul_sum[0], lo_q[DataWidth-1:1]};
    end
    prod     = {it_hi, it_lo};
    prod_fix = negr_q ? -prod : prod;
    quo      = negr_q ? -it_lo : it_lo;
    remv     = nega_q ? -it_hi : it_hi;
    unique case (op_q)
      OP_MUL:                        fin = prod_fix[DataWidth-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  fin = prod_fix[2*DataWidth-1:DataWidth];
      OP_DIV, OP_DIVU:               fin = quo;
      default:                       fin = remv;
    endcase
  end

  // FSM next state, operand capture and result update
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    m_d      = m_q;
    negr_d   = negr_q;
    nega_d   = nega_q;
    result_d = result_q;
    status_d = status_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          op_d   = op_in;
          negr_d = a_neg ^ b_neg;
          nega_d = a_neg;
          cnt_d  = CntLast;
          hi_d   = '0;
          m_d    = funct3[2] ? b_mag : a_mag;
          lo_d   = funct3[2] ? a_mag : b_mag;
          if (fast) begin
            state_d  = DONE;
            result_d = fast_res;
            status_d = flags(fast_res);
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        hi_d  = it_hi;
        lo_d  = it_lo;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d  = DONE;
          result_d = fin;
          status_d = flags(fin);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and architecturally visible result, async reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      status_q <= 4'b0100;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      status_q <= status_d;
    end
  end

  // Working datapath registers, always reloaded on start so no reset needed
  always_ff @(posedge clk) begin
    op_q   <= op_d;
    hi_q   <= hi_d;
    lo_q   <= lo_d;
    m_q    <= m_d;
    negr_q <= negr_d;
    nega_q <= nega_d;
  end

  assign busy   = (state_q == CALC);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign status = status_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: the driver pushes expected result,
// status and latency; a monitor pops and compares on every done pulse.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [2:0]  funct3;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] result;
  logic [3:0]  status;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EO = 1'b1;
`else
  localparam bit EO = 1'b0;
`endif
  localparam int EOL = EO ? 1 : 33;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic [3:0]  st;
    int          lat;
    int          start_cyc;
  } exp_t;

  exp_t sb[$];

  muldiv_unit #(.DataWidth(32)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .status(status)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    case (op)
      3'd0: begin p = {{32{x[31]}}, x} * {{32{y[31]}}, y}; return p[31:0]; end
      3'd1: begin p = {{32{x[31]}}, x} * {{32{y[31]}}, y}; return p[63:32]; end
      3'd2: begin p = {{32{x[31]}}, x} * {32'd0, y};       return p[63:32]; end
      3'd3: begin p = {32'd0, x} * {32'd0, y};             return p[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
        return 32'($signed(x) / $signed(y));
      end
      3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: begin
        if (y == 0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
        return 32'($signed(x) % $signed(y));
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    logic        sgn;
    logic [31:0] mx, my;
    sgn = (op == 3'd4 || op == 3'd6);
    mx  = (sgn && x[31]) ? -x : x;
    my  = (sgn && y[31]) ? -y : y;
    if (op[2]) begin
      if (y == 0) return 1;
      if (sgn && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
      if (EO && mx < my) return 1;
    end else if (EO && (x == 0 || y == 0)) begin
      return 1;
    end
    return 33;
  endfunction

  // Call at a negedge: start is sampled at the following posedge
  task automatic issue_now(input string name, input logic [2:0] op, input logic [31:0] av,
                           input logic [31:0] bv, input logic [31:0] res, input int lat);
    exp_t e;
    start = 1'b1; funct3 = op; a = av; b = bv;
    e.name = name; e.res = res; e.st = {res[31], res == 32'd0, 2'b00};
    e.lat = lat; e.start_cyc = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic issue(input string name, input logic [2:0] op, input logic [31:0] av,
                       input logic [31:0] bv, input logic [31:0] res, input int lat);
    @(negedge clk);
    issue_now(name, op, av, bv, res, lat);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain_timeout: %0d operations still pending, required 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  // Monitor: every done pulse must match the oldest pending expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && done) begin
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_done: result %h, required no done pulse", result);
        end else begin
          e = sb.pop_front();
          chk({e.name, "_result"}, result, e.res);
          chk({e.name, "_status"}, 32'(status), 32'(e.st));
          chk({e.name, "_latency"}, 32'(cyc - e.start_cyc + 1), 32'(e.lat));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    int          n;

    rst = 1'b1; start = 1'b0; funct3 = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_status", 32'(status), 32'b0100);
    rst = 1'b0;

    issue("mul_7_m3",     3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    drain();
    issue("mulhu_max",    3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    drain();
    issue("mulh_min",     3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33);
    drain();
    issue("mulhsu_m1_2",  3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 33);
    drain();
    issue("div_m7_2",     3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33);
    drain();
    issue("rem_m7_2",     3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33);
    drain();
    issue("rem_m5_3",     3'd6, 32'hFFFF_FFFB,  32'd3,         32'hFFFF_FFFE, 33);
    drain();
    issue("divu_by0",     3'd5, 32'd100,        32'd0,         32'hFFFF_FFFF, 1);
    drain();
    issue("remu_by0",     3'd7, 32'd5,          32'd0,         32'd5,         1);
    drain();
    issue("div_ovf",      3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
    drain();
    issue("rem_ovf",      3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1);
    drain();
    issue("mul_zero",     3'd0, 32'd0,          32'd5,         32'd0,         EOL);
    drain();
    issue("divu_small",   3'd5, 32'd3,          32'd10,        32'd0,         EOL);
    drain();
    issue("remu_small",   3'd7, 32'd3,          32'd10,        32'd3,         EOL);
    drain();
    issue("div_5_m8",     3'd4, 32'd5,          32'hFFFF_FFF8, 32'd0,         EOL);
    drain();
    issue("rem_5_m8",     3'd6, 32'd5,          32'hFFFF_FFF8, 32'd5,         EOL);
    drain();

    // Back-to-back: start held during DONE of the first op
    issue("b2b_divu", 3'd5, 32'd100, 32'd7, 32'd14, 33);
    n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_done_seen", 32'(done), 32'd1);
    issue_now("b2b_remu", 3'd7, 32'd100, 32'd7, 32'd2, 33);
    drain();

    // start pulses while busy must be ignored
    issue("mul_ignore", 3'd0, 32'd7, 32'd6, 32'd42, 33);
    repeat (3) begin
      @(negedge clk);
      chk("ignore_busy", 32'(busy), 32'd1);
      start = 1'b1; funct3 = 3'd5; a = 32'd1; b = 32'd0;
      @(negedge clk);
      start = 1'b0;
    end
    drain();

    // Async reset in the middle of a calculation discards it
    @(negedge clk);
    start = 1'b1; funct3 = 3'd0; a = 32'd7; b = 32'd6;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_result", result, 32'd0);
    chk("midrst_status", 32'(status), 32'b0100);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("midrst_idle", 32'(busy), 32'd0);

    // Random operations against the reference model
    for (int i = 0; i < 64; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = $urandom_range(0, 20);
        1:       ra = $urandom_range(0, 50);
        default: ;
      endcase
      if (rb === 'x || rb == ra) rb = $urandom;
      issue("rand", rop, ra, rb, ref_res(rop, ra, rb), ref_lat(rop, ra, rb));
      drain();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
